// File: rtl/exception_cause_ctrl.sv
// exception_cause_ctrl
// Producer side of the error-cause register. Collects synchronous exception
// pulses and the level interrupt, picks the highest-priority cause, strobes it
// into the error-target register and holds a redirect request to the
// multicycle control FSM until that FSM acknowledges. Handler mode is then
// tracked until ERET. A synchronous exception inside the handler is a double
// fault: C_DOUBLE is reported once and the block parks in a fatal state that
// only reset leaves.
//
// Optional build macro EXC_COUNT_EN adds a saturating 16-bit commit counter
// (exc_count) with a synchronous clear input (exc_count_clr).
module exception_cause_ctrl #(
  parameter int unsigned          CAUSE_W    = 5,
  parameter logic [CAUSE_W-1:0]   C_MISALIGN = 5'd4,
  parameter logic [CAUSE_W-1:0]   C_UNDEF    = 5'd10,
  parameter logic [CAUSE_W-1:0]   C_SYSCALL  = 5'd8,
  parameter logic [CAUSE_W-1:0]   C_OVF      = 5'd12,
  parameter logic [CAUSE_W-1:0]   C_IRQ      = 5'd0,
  parameter logic [CAUSE_W-1:0]   C_DOUBLE   = 5'd31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               misalign,
  input  logic               undef,
  input  logic               syscall,
  input  logic               ovf,
  input  logic               irq,
  input  logic               irq_en,
  input  logic               instr_boundary,
  input  logic               eret,
  input  logic               exc_ack,
  output logic               ErWrite,
  output logic [CAUSE_W-1:0] Er_i,
  output logic               exc_req,
  output logic               in_handler,
`ifdef EXC_COUNT_EN
  input  logic               exc_count_clr,
  output logic [15:0]        exc_count,
`endif
  output logic               fatal
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COMMIT   = 3'd1,
    ACK_WAIT = 3'd2,
    HANDLER  = 3'd3,
    HALT     = 3'd4
  } state_t;

  state_t             state_r, state_next_s;
  logic [4:0]         pend_r, pend_next_s;       // {misalign, undef, syscall, ovf, irq}
  logic [CAUSE_W-1:0] er_i_r, er_i_next_s;
  logic               cause_irq_r, cause_irq_next_s;  // committed cause was the interrupt
  logic               fatal_r, fatal_next_s;          // HALT has already reported C_DOUBLE
  logic [3:0]         sync_pulse_s;

  // Highest-priority synchronous cause: misalign > undef > syscall > ovf.
  function automatic logic [CAUSE_W-1:0] sync_code(input logic [3:0] s);
    if (s[3]) begin
      return C_MISALIGN;
    end else if (s[2]) begin
      return C_UNDEF;
    end else if (s[1]) begin
      return C_SYSCALL;
    end else begin
      return C_OVF;
    end
  endfunction

  assign sync_pulse_s = {misalign, undef, syscall, ovf};

  // Next-state, pending-vector and cause-code selection.
  always_comb begin
    state_next_s     = state_r;
    pend_next_s      = pend_r;
    er_i_next_s      = er_i_r;
    cause_irq_next_s = cause_irq_r;
    fatal_next_s     = fatal_r;
    case (state_r)
      IDLE: begin
        pend_next_s[4:1] = pend_r[4:1] | sync_pulse_s;
        pend_next_s[0]   = (pend_r[0] | irq) & irq_en;
        if (|pend_next_s[4:1]) begin
          state_next_s     = COMMIT;
          er_i_next_s      = sync_code(pend_next_s[4:1]);
          cause_irq_next_s = 1'b0;
        end else if (pend_r[0] & irq_en & instr_boundary) begin
          state_next_s     = COMMIT;
          er_i_next_s      = C_IRQ;
          cause_irq_next_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      COMMIT: begin
        // The aborted instruction drops any lower sync causes; a pending
        // interrupt survives unless it was the one just committed.
        pend_next_s[4:1] = 4'b0000;
        if (cause_irq_r) begin
          pend_next_s[0] = 1'b0;
        end else begin
          pend_next_s[0] = pend_r[0];
        end
        if (exc_ack) begin
          state_next_s = HANDLER;
        end else begin
          state_next_s = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        if (exc_ack) begin
          state_next_s = HANDLER;
        end else begin
          state_next_s = ACK_WAIT;
        end
      end
      HANDLER: begin
        if (|sync_pulse_s) begin
          state_next_s = HALT;
          er_i_next_s  = C_DOUBLE;
        end else if (eret) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HANDLER;
        end
      end
      HALT: begin
        state_next_s = HALT;
        fatal_next_s = 1'b1;
      end
      default: begin
        state_next_s = IDLE;
        pend_next_s  = 5'b00000;
      end
    endcase
  end

  // Control state, pending vector and registered cause code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      pend_r      <= 5'b00000;
      er_i_r      <= {CAUSE_W{1'b0}};
      cause_irq_r <= 1'b0;
      fatal_r     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      pend_r      <= pend_next_s;
      er_i_r      <= er_i_next_s;
      cause_irq_r <= cause_irq_next_s;
      fatal_r     <= fatal_next_s;
    end
  end

  assign ErWrite    = (state_r == COMMIT) | ((state_r == HALT) & ~fatal_r);
  assign Er_i       = er_i_r;
  assign exc_req    = (state_r == COMMIT) | (state_r == ACK_WAIT);
  assign in_handler = (state_r == HANDLER) | (state_r == HALT);
  assign fatal      = fatal_r;

`ifdef EXC_COUNT_EN
  logic [15:0] exc_count_r;

  // Saturating count of committed exceptions; clear wins over increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_count_r <= 16'h0000;
    end else if (exc_count_clr) begin
      exc_count_r <= 16'h0000;
    end else if ((state_r == COMMIT) && (exc_count_r != 16'hFFFF)) begin
      exc_count_r <= exc_count_r + 16'h0001;
    end else begin
      exc_count_r <= exc_count_r;
    end
  end

  assign exc_count = exc_count_r;
`endif

endmodule

// File: tb/tb_exception_cause_ctrl.sv
// Self-checking bench for exception_cause_ctrl: a fixed vector table, a few
// timed sequences and a randomized run against a behavioural reference model.
module tb_exception_cause_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       misalign, undef, syscall, ovf, irq, irq_en, instr_boundary, eret, exc_ack;
  logic       ErWrite, exc_req, in_handler, fatal;
  logic [4:0] Er_i;
`ifdef EXC_COUNT_EN
  logic        exc_count_clr;
  logic [15:0] exc_count;
`endif

  int checks = 0;
  int errors = 0;

  exception_cause_ctrl dut (
    .clk(clk), .reset(reset),
    .misalign(misalign), .undef(undef), .syscall(syscall), .ovf(ovf),
    .irq(irq), .irq_en(irq_en), .instr_boundary(instr_boundary),
    .eret(eret), .exc_ack(exc_ack),
    .ErWrite(ErWrite), .Er_i(Er_i), .exc_req(exc_req), .in_handler(in_handler),
`ifdef EXC_COUNT_EN
    .exc_count_clr(exc_count_clr), .exc_count(exc_count),
`endif
    .fatal(fatal)
  );

  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [8:0] v);
    {misalign, undef, syscall, ovf, irq, irq_en, instr_boundary, eret, exc_ack} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(9'b0);
`ifdef EXC_COUNT_EN
    exc_count_clr = 1'b0;
`endif
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Tracks the handshake as a few flags: an outstanding request, whether
  // this is its strobe cycle, handler/double-fault progress, the latched
  // interrupt and the last reported cause.
  bit         m_req, m_write, m_handler, m_halting, m_fatal, m_irq, m_took_irq;
  logic [4:0] m_cause;
  int         m_count;

  task model_reset();
    m_req = 0; m_write = 0; m_handler = 0; m_halting = 0; m_fatal = 0;
    m_irq = 0; m_took_irq = 0; m_cause = 5'd0; m_count = 0;
  endtask

  task model_step();
    bit sync, was_irq, in_commit;
    logic [4:0] code;
    sync      = misalign | undef | syscall | ovf;
    was_irq   = m_irq;
    in_commit = m_req && m_write;
`ifdef EXC_COUNT_EN
    if (exc_count_clr) m_count = 0;
    else if (in_commit && m_count < 65535) m_count++;
`endif
    if (m_fatal) begin
      m_write = 0;
    end else if (m_halting) begin
      m_halting = 0; m_fatal = 1; m_write = 0;
    end else if (m_handler) begin
      if (sync) begin
        m_halting = 1; m_write = 1; m_cause = 5'd31;
      end else if (eret) begin
        m_handler = 0;
      end
    end else if (m_req) begin
      if (m_write && m_took_irq) m_irq = 0;
      m_write = 0;
      if (exc_ack) begin
        m_req = 0; m_handler = 1;
      end
    end else begin
      m_irq = (m_irq | irq) & irq_en;
      m_took_irq = 0;
      if (misalign) code = 5'd4;
      else if (undef) code = 5'd10;
      else if (syscall) code = 5'd8;
      else code = 5'd12;
      if (sync) begin
        m_cause = code; m_req = 1; m_write = 1;
      end else if (was_irq && irq_en && instr_boundary) begin
        m_cause = 5'd0; m_req = 1; m_write = 1; m_took_irq = 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".ErWrite"}, 32'(ErWrite), 32'(m_write));
    check({tag, ".Er_i"}, 32'(Er_i), 32'(m_cause));
    check({tag, ".exc_req"}, 32'(exc_req), 32'(m_req));
    check({tag, ".in_handler"}, 32'(in_handler), 32'(m_handler | m_halting | m_fatal));
    check({tag, ".fatal"}, 32'(fatal), 32'(m_fatal));
`ifdef EXC_COUNT_EN
    check({tag, ".exc_count"}, 32'(exc_count), 32'(m_count));
`endif
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [8:0] in;   // {misalign, undef, syscall, ovf, irq, irq_en, instr_boundary, eret, exc_ack}
    logic       erw;
    logic [4:0] eri;
    logic       req;
    logic       inh;
    logic       fat;
  } vec_t;

  function automatic vec_t mk(input logic [8:0] in, input logic erw, input logic [4:0] eri,
                              input logic req, input logic inh, input logic fat);
    vec_t v;
    v.in = in; v.erw = erw; v.eri = eri; v.req = req; v.inh = inh; v.fat = fat;
    return v;
  endfunction

  vec_t vecs [0:13];

  initial begin
    // Expected outputs are those seen just after the edge that samples 'in'.
    vecs[0]  = mk(9'b0_1_0_1_1_1_0_0_0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0); // undef+ovf+irq -> undef
    vecs[1]  = mk(9'b1_0_0_0_1_1_0_0_0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0); // misalign ignored in ACK_WAIT
    vecs[2]  = mk(9'b0_0_0_0_1_1_0_0_1, 1'b0, 5'd10, 1'b0, 1'b1, 1'b0); // ack -> handler
    vecs[3]  = mk(9'b0_0_0_0_0_1_0_1_0, 1'b0, 5'd10, 1'b0, 1'b0, 1'b0); // eret -> idle
    vecs[4]  = mk(9'b0_0_0_0_0_1_1_0_0, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0); // boundary -> pending irq
    vecs[5]  = mk(9'b0_0_0_0_0_1_0_0_1, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0); // ack same cycle as commit
    vecs[6]  = mk(9'b0_0_0_0_0_1_0_1_1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0); // eret (ack ignored)
    vecs[7]  = mk(9'b0_0_0_0_0_1_1_1_1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0); // irq consumed; eret/ack ignored
    vecs[8]  = mk(9'b1_1_1_1_0_0_0_0_0, 1'b1, 5'd4,  1'b1, 1'b0, 1'b0); // all sync -> misalign
    vecs[9]  = mk(9'b0_0_0_0_0_0_0_0_1, 1'b0, 5'd4,  1'b0, 1'b1, 1'b0);
    vecs[10] = mk(9'b0_0_1_0_0_0_0_1_0, 1'b1, 5'd31, 1'b0, 1'b1, 1'b0); // syscall beats eret
    vecs[11] = mk(9'b0_0_0_0_0_0_0_0_0, 1'b0, 5'd31, 1'b0, 1'b1, 1'b1);
    vecs[12] = mk(9'b0_0_0_1_0_0_0_1_0, 1'b0, 5'd31, 1'b0, 1'b1, 1'b1); // fatal sticky
    vecs[13] = mk(9'b0_0_0_0_0_0_0_0_1, 1'b0, 5'd31, 1'b0, 1'b1, 1'b1);
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b0;
    set_in(9'b0);
`ifdef EXC_COUNT_EN
    exc_count_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset.ErWrite", 32'(ErWrite), 32'd0);
    check("reset.Er_i", 32'(Er_i), 32'd0);
    check("reset.exc_req", 32'(exc_req), 32'd0);
    check("reset.in_handler", 32'(in_handler), 32'd0);
    check("reset.fatal", 32'(fatal), 32'd0);
    reset = 1'b1;

    // Idle for 20 cycles: nothing may be strobed.
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle.ErWrite", 32'(ErWrite), 32'd0);
      check("idle.exc_req", 32'(exc_req), 32'd0);
    end

    // Vector table.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].in);
      tick();
      check($sformatf("vec%0d.ErWrite", i), 32'(ErWrite), 32'(vecs[i].erw));
      check($sformatf("vec%0d.Er_i", i), 32'(Er_i), 32'(vecs[i].eri));
      check($sformatf("vec%0d.exc_req", i), 32'(exc_req), 32'(vecs[i].req));
      check($sformatf("vec%0d.in_handler", i), 32'(in_handler), 32'(vecs[i].inh));
      check($sformatf("vec%0d.fatal", i), 32'(fatal), 32'(vecs[i].fat));
    end

    // ovf at cycle 10, ack at 13, eret at 20; observations belong to cycle c+1.
    do_reset();
    for (int c = 0; c < 24; c++) begin
      set_in({3'b000, c == 10, 3'b000, c == 20, c == 13});
      tick();
      check($sformatf("ovf_seq%0d.ErWrite", c + 1), 32'(ErWrite), 32'(c + 1 == 11));
      check($sformatf("ovf_seq%0d.exc_req", c + 1), 32'(exc_req), 32'((c + 1 >= 11) && (c + 1 <= 13)));
      check($sformatf("ovf_seq%0d.in_handler", c + 1), 32'(in_handler), 32'((c + 1 >= 14) && (c + 1 <= 20)));
      check($sformatf("ovf_seq%0d.Er_i", c + 1), 32'(Er_i), (c + 1 >= 11) ? 32'd12 : 32'd0);
    end

    // irq held with irq_en, boundary only at cycle 8.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      set_in({4'b0000, 1'b1, 1'b1, c == 8, 2'b00});
      tick();
      check($sformatf("irq_seq%0d.ErWrite", c + 1), 32'(ErWrite), 32'(c + 1 == 9));
      check($sformatf("irq_seq%0d.exc_req", c + 1), 32'(exc_req), 32'(c + 1 >= 9));
    end

    // irq without irq_en never commits.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      set_in(9'b0_0_0_0_1_0_1_0_0);
      tick();
      check("irq_dis.exc_req", 32'(exc_req), 32'd0);
    end

    // Reset mid-handshake drops the request and strobe without a clock edge.
    do_reset();
    set_in(9'b0_0_0_1_0_0_0_0_0);
    tick();
    set_in(9'b0);
    check("midrst.pre_ErWrite", 32'(ErWrite), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst.ErWrite", 32'(ErWrite), 32'd0);
    check("midrst.exc_req", 32'(exc_req), 32'd0);
    check("midrst.Er_i", 32'(Er_i), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

`ifdef EXC_COUNT_EN
    // Three commits, then a clear during a COMMIT cycle.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(9'b0_0_0_1_0_0_0_0_0); tick();
      set_in(9'b0_0_0_0_0_0_0_0_1); tick();
      set_in(9'b0_0_0_0_0_0_0_1_0); tick();
    end
    set_in(9'b0);
    tick();
    check("count.three", 32'(exc_count), 32'd3);
    set_in(9'b0_0_0_1_0_0_0_0_0); tick();
    set_in(9'b0);
    exc_count_clr = 1'b1;
    tick();
    exc_count_clr = 1'b0;
    check("count.clr_wins", 32'(exc_count), 32'd0);
    tick();
    check("count.no_inc_ackwait", 32'(exc_count), 32'd0);
`endif

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    begin
      int fatal_cycles;
      fatal_cycles = 0;
      for (int c = 0; c < 4000; c++) begin
        misalign       = ($urandom_range(0, 39) == 0);
        undef          = ($urandom_range(0, 39) == 0);
        syscall        = ($urandom_range(0, 39) == 0);
        ovf            = ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 5) == 0) irq = ~irq;
        irq_en         = ($urandom_range(0, 7) != 0);
        instr_boundary = ($urandom_range(0, 3) == 0);
        eret           = ($urandom_range(0, 7) == 0);
        exc_ack        = ($urandom_range(0, 3) == 0);
`ifdef EXC_COUNT_EN
        exc_count_clr  = ($urandom_range(0, 63) == 0);
`endif
        @(posedge clk);
        model_step();
        #1;
        check_model("rand");
        fatal_cycles = m_fatal ? fatal_cycles + 1 : 0;
        if (fatal_cycles > 3 || $urandom_range(0, 299) == 0) begin
          reset = 1'b0;
          #1;
          model_reset();
          check_model("rand_rst");
          set_in(9'b0);
`ifdef EXC_COUNT_EN
          exc_count_clr = 1'b0;
`endif
          @(posedge clk);
          #1;
          reset = 1'b1;
          fatal_cycles = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_cause_ctrl.md
Name: exception_cause_ctrl

Overview:
- Producer side of the error-cause register: collects exception/interrupt sources, prioritises them and drives the 5-bit cause code plus its write strobe to the error-target register.
- Handshakes with the multicycle control FSM: raises a redirect request to the exception vector and holds it until acknowledged.
- Tracks handler mode until ERET.
- Sits beside the main control unit in the multicycle CPU.

Parameters:
- CAUSE_W, 5, width of cause code.
- C_MISALIGN, 5'd4, cause code: fetch PC not word-aligned.
- C_UNDEF, 5'd10, cause code: undefined opcode/funct.
- C_SYSCALL, 5'd8, cause code: syscall instruction.
- C_OVF, 5'd12, cause code: signed arithmetic overflow.
- C_IRQ, 5'd0, cause code: external/timer interrupt.
- C_DOUBLE, 5'd31, cause code: synchronous exception while in handler.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- misalign  in  1  one-cycle pulse from fetch stage.
- undef  in  1  one-cycle pulse from decode.
- syscall  in  1  one-cycle pulse from decode.
- ovf  in  1  one-cycle pulse from ALU writeback.
- irq  in  1  level interrupt request.
- irq_en  in  1  global interrupt enable.
- instr_boundary  in  1  control FSM is in its fetch state (safe interrupt point).
- eret  in  1  one-cycle pulse: ERET executed.
- exc_ack  in  1  control FSM has redirected PC to the vector.
- ErWrite  out  1  write strobe to error-target register.
- Er_i  out  CAUSE_W  cause code for error-target register.
- exc_req  out  1  redirect request to control FSM.
- in_handler  out  1  handler mode active.
- fatal  out  1  double fault; sticky until reset.

Behaviour:
- Reset (reset=0, async): state=IDLE, pend=0; all outputs 0, including Er_i.
- Pending vector pend[4:0] = {misalign, undef, syscall, ovf, irq}.
  - Sync bits set on their input pulse in IDLE.
  - irq bit set while irq&irq_en in IDLE; cleared if irq_en drops before commit.
- Priority: misalign > undef > syscall > ovf > irq.
- States: IDLE, COMMIT, ACK_WAIT, HANDLER, HALT. All outputs are registered or decoded from registered state only.
- IDLE:
  - Go to COMMIT next cycle if any sync pulse is present in the current cycle or pend has a sync bit.
  - Otherwise go to COMMIT if pend.irq & instr_boundary.
- COMMIT (exactly 1 cycle):
  - ErWrite=1; Er_i = code of highest-priority pending source (registered, held afterwards); exc_req=1.
  - All sync pend bits are cleared: the aborted instruction discards lower sync causes.
  - pend.irq is cleared only if irq was the committed cause.
  - If exc_ack=1 this cycle, go to HANDLER; else go to ACK_WAIT.
- ACK_WAIT: exc_req=1, ErWrite=0; stay until exc_ack=1, then go to HANDLER.
- HANDLER:
  - in_handler=1; irq not latched.
  - eret go to IDLE next cycle; in_handler drops in that cycle.
  - Any sync pulse go to HALT; takes priority over a simultaneous eret.
- HALT:
  - One cycle ErWrite=1, Er_i=C_DOUBLE.
  - Then fatal=1, exc_req=0, in_handler=1, held until reset.
- Boundary cases:
  - eret outside HANDLER: ignored.
  - exc_ack outside COMMIT/ACK_WAIT: ignored.
  - Sync pulses during COMMIT/ACK_WAIT: ignored, since the instruction is already being aborted.
  - irq arriving with a sync pulse in the same cycle: sync cause committed first; irq remains pending and is taken after ERET at the next instruction_boundary.
  - Reset mid-handshake: immediate return to IDLE; exc_req and ErWrite drop asynchronously.
- Latency: sync pulse at cycle N gives ErWrite/exc_req at N+1. irq gives ErWrite one cycle after the first instr_boundary with irq pending.

Optional Feature:
- Macro: EXC_COUNT_EN.
- Defined:
  - Adds output exc_count [15:0], incremented on every COMMIT cycle (not HALT).
  - Saturates at 16'hFFFF; reset value 0.
  - Adds input exc_count_clr (synchronous clear); clear wins over a same-cycle increment.
- Undefined: no counter logic and no extra ports.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, release → all outputs 0, no ErWrite for 20 cycles.
- ovf pulse at cycle 10, exc_ack at 13 → ErWrite=1 only at 11 with Er_i=12; exc_req high 11–13; in_handler=1 from 14; eret at 20 → in_handler=0 at 21.
- undef+ovf+irq (irq_en=1) same cycle → Er_i=10 committed; after ack, then eret, then instr_boundary → second ErWrite with Er_i=0.
- irq high, irq_en=1, instr_boundary low until cycle 8 → ErWrite at 9, Er_i=0; with irq_en=0 → no commit.
- syscall in HANDLER with simultaneous eret → ErWrite, Er_i=31, then fatal=1 held; only reset clears.
- EXC_COUNT_EN: 3 committed exceptions → exc_count=3; exc_count_clr with a commit in the same cycle → 0.
